// File: rtl/updown_counter_gen.sv
// ---------------------------------------------------------------------------
// updown_counter_gen
//   Parametrised up/down counter. It supports preload, count enable, a
//   programmable step, an arbitrary modulus, and either wrap or saturate
//   handling at the ends of the range. It flags the terminal counts and
//   pulses on wrap/saturation and on a clamped preload.
//
// Parameters
//   WIDTH     counter width (2..32)
//   MODULUS   count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
//   STEP_W    width of the step input
//   SAT_MODE  0 = wrap modulo MODULUS, 1 = saturate at 0 / MODULUS-1
//   RST_VAL   qout after reset (< MODULUS)
//
// Ports
//   clk      clock, rising edge
//   reset    asynchronous active-low reset
//   en       count enable
//   preload  load pl_data on the next edge (overrides en)
//   up_dn    1 = up, 0 = down
//   pl_data  preload value
//   step     amount added/subtracted per enabled edge
//   qout     registered count
//   at_max   qout == MODULUS-1
//   at_min   qout == 0
//   wrap     registered 1-cycle pulse: count wrapped or saturated
//   pl_err   registered 1-cycle pulse: preload value was clamped
// ---------------------------------------------------------------------------
module updown_counter_gen #(
   parameter int     WIDTH    = 8,
   parameter longint MODULUS  = 256,
   parameter int     STEP_W   = 4,
   parameter bit     SAT_MODE = 1'b0,
   parameter longint RST_VAL  = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              preload,
   input  logic              up_dn,
   input  logic [WIDTH-1:0]  pl_data,
   input  logic [STEP_W-1:0] step,
   output logic [WIDTH-1:0]  qout,
   output logic              at_max,
   output logic              at_min,
   output logic              wrap,
   output logic              pl_err
);

   // One spare bit above WIDTH+STEP_W so q+s never overflows.
   localparam int AW = WIDTH + STEP_W + 1;

   localparam logic [AW-1:0]    MOD_A = AW'(MODULUS);
   localparam logic [AW-1:0]    MAX_A = AW'(MODULUS - 1);
   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);

   logic [AW-1:0]    q_ext;
   logic [AW-1:0]    s_ext;
   logic [AW-1:0]    pl_ext;
   logic [AW-1:0]    s_rem;
   logic [AW-1:0]    sum;
   logic [AW-1:0]    up_rem;
   logic [AW-1:0]    wrap_up;
   logic [AW-1:0]    wrap_dn;
   logic [WIDTH-1:0] nxt_q;
   logic             nxt_wrap;
   logic             nxt_err;

   always_comb begin
      q_ext  = AW'(qout);
      s_ext  = AW'(step);
      pl_ext = AW'(pl_data);
      sum    = q_ext + s_ext;

      // Remainder by a constant divisor: lets a step larger than the modulus
      // wrap correctly in one edge. Since q < MODULUS and s_rem < MODULUS,
      // one conditional subtract/add finishes the reduction.
      s_rem   = s_ext % MOD_A;
      up_rem  = q_ext + s_rem;
      wrap_up = (up_rem >= MOD_A) ? (up_rem - MOD_A) : up_rem;
      wrap_dn = (s_rem > q_ext) ? (q_ext + MOD_A - s_rem) : (q_ext - s_rem);

      nxt_q    = qout;
      nxt_wrap = 1'b0;
      nxt_err  = 1'b0;

      if (preload) begin
         if (pl_ext >= MOD_A) begin
            nxt_q   = MAX_Q;
            nxt_err = 1'b1;
         end else begin
            nxt_q = pl_data;
         end
      end else if (en && (step != '0)) begin
         if (up_dn) begin
            if (sum > MAX_A) begin
               nxt_wrap = 1'b1;
               nxt_q    = SAT_MODE ? MAX_Q : WIDTH'(wrap_up);
            end else begin
               nxt_q = WIDTH'(sum);
            end
         end else begin
            if (s_ext > q_ext) begin
               nxt_wrap = 1'b1;
               nxt_q    = SAT_MODE ? '0 : WIDTH'(wrap_dn);
            end else begin
               nxt_q = WIDTH'(q_ext - s_ext);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         qout   <= RST_Q;
         wrap   <= 1'b0;
         pl_err <= 1'b0;
      end else begin
         qout   <= nxt_q;
         wrap   <= nxt_wrap;
         pl_err <= nxt_err;
      end
   end

   assign at_max = (qout == MAX_Q);
   assign at_min = (qout == '0);

endmodule

// File: tb/tb_updown_counter_gen.sv
// ---------------------------------------------------------------------------
// tb_updown_counter_gen
//   Three counters share one stimulus stream:
//     A: WIDTH 8, MODULUS 256, wrap
//     B: WIDTH 4, MODULUS 10,  wrap
//     C: WIDTH 8, MODULUS 256, saturate
//   An integer-arithmetic model predicts each counter. A compare process
//   checks every output on every falling edge, and directed checks pin
//   hand-computed values.
// ---------------------------------------------------------------------------
module tb_updown_counter_gen;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b0;
   logic       preload = 1'b0;
   logic       up_dn = 1'b1;
   logic [7:0] pl_data = '0;
   logic [3:0] step = 4'd1;
   logic [3:0] pl_b;

   logic [7:0] qa, qc;
   logic [3:0] qb;
   logic       maxa, mina, wa, ea;
   logic       maxb, minb, wb, eb;
   logic       maxc, minc, wc, ec;

   int checks = 0;
   int errors = 0;

   int mq[3] = '{0, 0, 0};
   int mw[3] = '{0, 0, 0};
   int me[3] = '{0, 0, 0};
   int mod_of[3] = '{256, 10, 256};
   int sat_of[3] = '{0, 0, 1};

   assign pl_b = pl_data[3:0];

   always #5 clk = ~clk;

   updown_counter_gen #(.WIDTH(8), .MODULUS(256), .STEP_W(4), .SAT_MODE(1'b0), .RST_VAL(0)) dut_a (
      .clk(clk), .reset(reset), .en(en), .preload(preload), .up_dn(up_dn),
      .pl_data(pl_data), .step(step), .qout(qa), .at_max(maxa), .at_min(mina),
      .wrap(wa), .pl_err(ea));

   updown_counter_gen #(.WIDTH(4), .MODULUS(10), .STEP_W(4), .SAT_MODE(1'b0), .RST_VAL(0)) dut_b (
      .clk(clk), .reset(reset), .en(en), .preload(preload), .up_dn(up_dn),
      .pl_data(pl_b), .step(step), .qout(qb), .at_max(maxb), .at_min(minb),
      .wrap(wb), .pl_err(eb));

   updown_counter_gen #(.WIDTH(8), .MODULUS(256), .STEP_W(4), .SAT_MODE(1'b1), .RST_VAL(0)) dut_c (
      .clk(clk), .reset(reset), .en(en), .preload(preload), .up_dn(up_dn),
      .pl_data(pl_data), .step(step), .qout(qc), .at_max(maxc), .at_min(minc),
      .wrap(wc), .pl_err(ec));

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Next-state rule written as plain integer arithmetic.
   task automatic model_step(input int q, input int m, input int sat, input int pre,
                             input int pd, input int e, input int up, input int s,
                             output int nq, output int nw, output int ne);
      nq = q; nw = 0; ne = 0;
      if (pre != 0) begin
         if (pd >= m) begin nq = m - 1; ne = 1; end
         else nq = pd;
      end else if (e != 0 && s != 0) begin
         if (up != 0) begin
            if (q + s >= m) begin nw = 1; nq = (sat != 0) ? m - 1 : (q + s) % m; end
            else nq = q + s;
         end else begin
            if (s > q) begin nw = 1; nq = (sat != 0) ? 0 : (((q - s) % m) + m) % m; end
            else nq = q - s;
         end
      end
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 3; i++) begin mq[i] = 0; mw[i] = 0; me[i] = 0; end
      end else begin
         for (int i = 0; i < 3; i++) begin
            int nq, nw, ne, pd;
            pd = (i == 1) ? int'(pl_b) : int'(pl_data);
            model_step(mq[i], mod_of[i], sat_of[i], int'(preload), pd, int'(en),
                       int'(up_dn), int'(step), nq, nw, ne);
            mq[i] = nq; mw[i] = nw; me[i] = ne;
         end
      end
   end

   always @(negedge clk) begin
      chk("a_q", int'(qa), mq[0]);   chk("a_wrap", int'(wa), mw[0]);   chk("a_plerr", int'(ea), me[0]);
      chk("a_max", int'(maxa), int'(mq[0] == 255)); chk("a_min", int'(mina), int'(mq[0] == 0));
      chk("b_q", int'(qb), mq[1]);   chk("b_wrap", int'(wb), mw[1]);   chk("b_plerr", int'(eb), me[1]);
      chk("b_max", int'(maxb), int'(mq[1] == 9));   chk("b_min", int'(minb), int'(mq[1] == 0));
      chk("c_q", int'(qc), mq[2]);   chk("c_wrap", int'(wc), mw[2]);   chk("c_plerr", int'(ec), me[2]);
      chk("c_max", int'(maxc), int'(mq[2] == 255)); chk("c_min", int'(minc), int'(mq[2] == 0));
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int seen;
      #1 reset = 1'b0;

      // 1) reset for 3 clocks, then count up 30
      repeat (3) @(posedge clk);
      #1;
      chk("t1_reset_q", int'(qa), 0);
      reset = 1'b1; en = 1'b1; up_dn = 1'b1; step = 4'd1;
      seen = 0;
      repeat (30) begin
         cyc();
         if (wa) seen = 1;
      end
      chk("t1_q30", int'(qa), 30);
      chk("t1_no_wrap", seen, 0);

      // 2) preload 50, then down 30
      pl_data = 8'd50; preload = 1'b1;
      cyc();
      chk("t2_pl50", int'(qa), 50);
      preload = 1'b0; up_dn = 1'b0;
      repeat (30) cyc();
      chk("t2_q20", int'(qa), 20);

      // 3) preload 254, up by 3 wraps to 1; down by 2 wraps to 255
      pl_data = 8'd254; preload = 1'b1; up_dn = 1'b1; step = 4'd3;
      cyc();
      chk("t3_pl254", int'(qa), 254);
      preload = 1'b0;
      cyc();
      chk("t3_q1", int'(qa), 1);
      chk("t3_wrap1", int'(wa), 1);
      en = 1'b0;
      cyc();
      chk("t3_wrap_pulse_end", int'(wa), 0);
      chk("t3_hold", int'(qa), 1);
      en = 1'b1; up_dn = 1'b0; step = 4'd2;
      cyc();
      chk("t3_q255", int'(qa), 255);
      chk("t3_wrap_dn", int'(wa), 1);

      // 4) modulus 10: preload 12 clamps to 9, then up 1 wraps to 0
      pl_data = 8'd12; preload = 1'b1; up_dn = 1'b1; step = 4'd1;
      cyc();
      chk("t4_b_clamp", int'(qb), 9);
      chk("t4_b_plerr", int'(eb), 1);
      chk("t4_b_atmax", int'(maxb), 1);
      chk("t4_a_noclamp", int'(ea), 0);
      preload = 1'b0;
      cyc();
      chk("t4_b_q0", int'(qb), 0);
      chk("t4_b_wrap", int'(wb), 1);
      chk("t4_b_plerr_end", int'(eb), 0);

      // 5) saturate: 253 up by 2 for 3 clocks
      pl_data = 8'd253; preload = 1'b1;
      cyc();
      preload = 1'b0; step = 4'd2; up_dn = 1'b1;
      cyc();
      chk("t5_c_q_1", int'(qc), 255); chk("t5_c_w_1", int'(wc), 0);
      cyc();
      chk("t5_c_q_2", int'(qc), 255); chk("t5_c_w_2", int'(wc), 1);
      cyc();
      chk("t5_c_q_3", int'(qc), 255); chk("t5_c_w_3", int'(wc), 1);

      // 6) en toggling for 10 clocks, then reset mid-cycle
      pl_data = 8'd0; preload = 1'b1;
      cyc();
      preload = 1'b0; step = 4'd1; up_dn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         en = (i % 2 == 0);
         cyc();
      end
      chk("t6_q5", int'(qa), 5);
      #2 reset = 1'b0;
      #1;
      chk("t6_async_q", int'(qa), 0);
      chk("t6_async_min", int'(mina), 1);
      chk("t6_async_c", int'(qc), 0);
      @(posedge clk);
      #1;
      reset = 1'b1; en = 1'b1;
      cyc();
      chk("t6_resume", int'(qa), 1);

      // 7) step 0 holds; saturate down clamps at 0 repeatedly
      step = 4'd0;
      cyc();
      chk("t7_step0_q", int'(qa), 1);
      chk("t7_step0_wrap", int'(wa), 0);
      up_dn = 1'b0; step = 4'd5;
      cyc();
      chk("t7_c_q0", int'(qc), 0);
      chk("t7_c_wrap", int'(wc), 1);
      chk("t7_b_q", int'(qb), 6);
      cyc();
      chk("t7_c_hold0", int'(qc), 0);
      chk("t7_c_wrap_again", int'(wc), 1);

      // 8) mixed sweep checked against the model every cycle
      for (int i = 0; i < 48; i++) begin
         step    = 4'((i * 7 + 3) % 16);
         up_dn   = (i % 3 != 0);
         en      = (i % 5 != 4);
         preload = (i % 11 == 7);
         pl_data = 8'((i * 37) % 256);
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
